// File: rtl/axi_to_ndata_gearbox_if.sv
// Stream bundles used by axi_to_ndata_gearbox.
//
// axi4s_if : wide AXI4-Stream beat (tdata/tkeep/tlast/tvalid, tready back).
//            master drives the payload, slave returns tready.
// ndata_if : narrow ndata beat of NUM_ELEMENTS elements with per-element keep
//            (data/keep/last/valid, ready back). master drives the payload,
//            slave returns ready.

interface axi4s_if #(
    parameter int unsigned AXI_WIDTH = 512
) ();
    logic [AXI_WIDTH-1:0]   tdata;
    logic [AXI_WIDTH/8-1:0] tkeep;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

interface ndata_if #(
    parameter type         data_t       = logic [31:0],
    parameter int unsigned NUM_ELEMENTS = 8
) ();
    data_t [NUM_ELEMENTS-1:0] data;
    logic  [NUM_ELEMENTS-1:0] keep;
    logic                     last;
    logic                     valid;
    logic                     ready;

    modport master (output data, output keep, output last, output valid, input ready);
    modport slave  (input data, input keep, input last, input valid, output ready);
endinterface

// File: rtl/axi_to_ndata_gearbox.sv
// AXI4-Stream to ndata gearbox.
//
// Splits each wide AXI4S beat into RATIO narrower ndata beats of NUM_ELEMENTS
// elements. Element i of slice s is the low $bits(data_t) bits of slot
// s*NUM_ELEMENTS+i; its keep is the tkeep bit of the slot's lowest byte.
// With DROP_EMPTY=1 the trailing all-empty slices of a tlast beat are not
// emitted (an all-empty tlast beat still produces one keep=0, last=1 beat).
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   in    : axi4s_if.slave  - wide input stream
//   out   : ndata_if.master - narrow output stream, driven from registers only

module axi_to_ndata_gearbox #(
    parameter type         data_t           = logic [31:0],
    parameter int unsigned NUM_ELEMENTS     = 8,
    parameter int unsigned AXI_WIDTH        = 512,
    parameter int unsigned NUM_AXI_ELEMENTS = AXI_WIDTH / $bits(data_t),
    parameter bit          DROP_EMPTY       = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    axi4s_if.slave   in,
    ndata_if.master  out
);

    localparam int unsigned DW         = $bits(data_t);
    localparam int unsigned SLOT_W     = AXI_WIDTH / NUM_AXI_ELEMENTS;
    localparam int unsigned SLOT_BYTES = SLOT_W / 8;
    localparam int unsigned RATIO      = NUM_AXI_ELEMENTS / NUM_ELEMENTS;
    localparam int unsigned SEL_W      = (RATIO > 1) ? $clog2(RATIO) : 1;

    if (AXI_WIDTH != SLOT_W * NUM_AXI_ELEMENTS) begin : g_chk_width
        $error("AXI_WIDTH must be a whole number of slots");
    end
    if (DW > SLOT_W) begin : g_chk_elem
        $error("data_t does not fit in one slot");
    end
    if (SLOT_W % 8 != 0) begin : g_chk_bytes
        $error("slot width must be a whole number of bytes");
    end
    if (NUM_AXI_ELEMENTS % NUM_ELEMENTS != 0) begin : g_chk_div
        $error("NUM_AXI_ELEMENTS must be a multiple of NUM_ELEMENTS");
    end
    if (RATIO < 1 || (RATIO & (RATIO - 1)) != 0) begin : g_chk_pow2
        $error("RATIO must be a power of two");
    end

    // Input beat viewed as [slice][element]
    data_t [RATIO-1:0][NUM_ELEMENTS-1:0] in_data;
    logic  [RATIO-1:0][NUM_ELEMENTS-1:0] in_keep;

    for (genvar s = 0; s < RATIO; s++) begin : g_slice
        for (genvar e = 0; e < NUM_ELEMENTS; e++) begin : g_elem
            assign in_data[s][e] = data_t'(in.tdata[(s*NUM_ELEMENTS+e)*SLOT_W +: DW]);
            assign in_keep[s][e] = in.tkeep[(s*NUM_ELEMENTS+e)*SLOT_BYTES];
        end
    end

    data_t [RATIO-1:0][NUM_ELEMENTS-1:0] hold_data;
    logic  [RATIO-1:0][NUM_ELEMENTS-1:0] hold_keep;
    logic                                hold_last;
    logic                                hold_valid;
    logic  [SEL_W-1:0]                   sel;
    logic  [SEL_W-1:0]                   last_slice;
    logic  [SEL_W-1:0]                   last_slice_d;
    logic                                final_slice;
    logic                                load;

    // Last slice to present for the incoming beat: highest slice with any
    // keep set on a tlast beat when dropping empties, otherwise the full beat.
    always_comb begin
        last_slice_d = '0;
        if (!in.tlast || !DROP_EMPTY) begin
            last_slice_d = SEL_W'(RATIO - 1);
        end else begin
            for (int unsigned s = 0; s < RATIO; s++) begin
                if (|in_keep[s]) begin
                    last_slice_d = SEL_W'(s);
                end
            end
        end
    end

    assign final_slice = (sel == last_slice);
    // The final slice's transfer frees the hold register in the same cycle,
    // so a new beat can be loaded without a bubble.
    assign in.tready   = !hold_valid || (out.ready && final_slice);
    assign load        = in.tvalid && in.tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_keep  <= '0;
            hold_last  <= 1'b0;
            hold_valid <= 1'b0;
            sel        <= '0;
            last_slice <= '0;
        end else if (load) begin
            hold_data  <= in_data;
            hold_keep  <= in_keep;
            hold_last  <= in.tlast;
            hold_valid <= 1'b1;
            sel        <= '0;
            last_slice <= last_slice_d;
        end else if (hold_valid && out.ready) begin
            if (final_slice) begin
                hold_valid <= 1'b0;
                sel        <= '0;
            end else begin
                sel        <= sel + 1'b1;
            end
        end
    end

    always_comb begin
        out.valid = hold_valid;
        out.last  = hold_last && final_slice;
        out.data  = hold_data[sel];
        out.keep  = hold_keep[sel];
    end

endmodule
